// File: rtl/sc_stream_gen.sv
// Binary-to-stochastic converter: encodes v (0..N) as an N-bit unipolar stream
// with exactly v ones, emitted serially and assembled into a parallel word.
module sc_stream_gen #(
  parameter  int unsigned K = 3,
  localparam int unsigned N = 2 ** K
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [K:0]   in_value,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         bit_out,
  output logic         bit_valid,
  output logic [N-1:0] word_out,
  output logic         word_valid,
  input  logic         word_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Maximal-length feedback taps (Fibonacci, shift toward MSB), indexed by K.
  function automatic logic [7:0] tap_mask(input int unsigned k);
    case (k)
      2:       tap_mask = 8'b0000_0011;
      3:       tap_mask = 8'b0000_0110;
      4:       tap_mask = 8'b0000_1100;
      5:       tap_mask = 8'b0001_0100;
      6:       tap_mask = 8'b0011_0000;
      7:       tap_mask = 8'b0110_0000;
      default: tap_mask = 8'b1011_1000;
    endcase
  endfunction

  localparam logic [7:0] TAPS = tap_mask(K);

  state_t         state_q, state_d;
  logic [K:0]     value_q, value_d;
  logic [K-1:0]   count_q, count_d;
  logic [K-1:0]   lfsr_q, lfsr_d;
  logic [N-1:0]   word_q, word_d;
  logic           bit_q, bit_d;
  logic           bit_valid_q, bit_valid_d;
  logic           word_valid_q, word_valid_d;
  logic           in_ready_q, in_ready_d;

  logic [K:0]     v_sat_c;
  logic [K-1:0]   lfsr_next_c;
  logic           fb_c;

  // De Bruijn insertion: toggling feedback when the low K-1 bits are zero
  // splices the all-zero state into the sequence, giving period N.
  always_comb begin
    fb_c        = (^(lfsr_q & TAPS[K-1:0])) ^ (lfsr_q[K-2:0] == '0);
    lfsr_next_c = {lfsr_q[K-2:0], fb_c};
    v_sat_c     = (in_value > (K+1)'(N)) ? (K+1)'(N) : in_value;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      value_q      <= '0;
      count_q      <= '0;
      lfsr_q       <= K'(1);
      word_q       <= '0;
      bit_q        <= 1'b0;
      bit_valid_q  <= 1'b0;
      word_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      value_q      <= value_d;
      count_q      <= count_d;
      lfsr_q       <= lfsr_d;
      word_q       <= word_d;
      bit_q        <= bit_d;
      bit_valid_q  <= bit_valid_d;
      word_valid_q <= word_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Next-state logic; output flops are loaded with the value for the coming cycle.
  always_comb begin
    state_d      = state_q;
    value_d      = value_q;
    count_d      = count_q;
    lfsr_d       = lfsr_q;
    word_d       = word_q;
    bit_d        = 1'b0;
    bit_valid_d  = 1'b0;
    word_valid_d = 1'b0;
    in_ready_d   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid) begin
          state_d     = RUN;
          value_d     = v_sat_c;
          count_d     = '0;
          word_d      = '0;
          bit_d       = ({1'b0, lfsr_q} < v_sat_c);
          bit_valid_d = 1'b1;
          in_ready_d  = 1'b0;
        end
      end
      RUN: begin
        word_d[count_q] = bit_q;
        count_d         = K'(count_q + 1'b1);
        lfsr_d          = lfsr_next_c;
        if (count_q == K'(N - 1)) begin
          state_d      = DONE;
          word_valid_d = 1'b1;
        end else begin
          bit_d       = ({1'b0, lfsr_next_c} < value_q);
          bit_valid_d = 1'b1;
        end
      end
      DONE: begin
        word_valid_d = 1'b1;
        if (word_ready) begin
          state_d      = IDLE;
          word_valid_d = 1'b0;
          in_ready_d   = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  assign in_ready   = in_ready_q;
  assign bit_out    = bit_q;
  assign bit_valid  = bit_valid_q;
  assign word_out   = word_q;
  assign word_valid = word_valid_q;

endmodule

// File: tb/tb_sc_stream_gen.sv
// Self-checking bench for sc_stream_gen (K=3, N=8) with an expected-value queue.
module tb_sc_stream_gen;
  localparam int unsigned K = 3;
  localparam int unsigned N = 8;

  logic         clk;
  logic         reset_n;
  logic [K:0]   in_value;
  logic         in_valid;
  logic         in_ready;
  logic         bit_out;
  logic         bit_valid;
  logic [N-1:0] word_out;
  logic         word_valid;
  logic         word_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];
  int last_accept;

  sc_stream_gen #(.K(K)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready),
    .bit_out(bit_out), .bit_valid(bit_valid),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Runs one stream starting at a negedge with the DUT idle. Returns at the
  // negedge after DONE is left (hold_ready) or at the first DONE negedge.
  task automatic stream(input int val, input bit hold_ready, input bit noisy);
    int exp_v, ones, nbits, k, first_k, done_k;
    logic [N-1:0] serial, seen, exp_word;
    logic [K-1:0] r;
    ones = 0; nbits = 0; first_k = -1; done_k = -1;
    serial = '0; seen = '0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL stream_in_ready v=%0d got %b want 1", val, in_ready);
    end
    in_value   = (K+1)'(val);
    in_valid   = 1'b1;
    word_ready = hold_ready;
    exp_q.push_back((val > N) ? N : val);
    @(posedge clk); #1;
    last_accept = cyc;
    in_valid = noisy;
    in_value = (K+1)'(3);
    for (k = 1; k <= N + 4; k++) begin
      @(negedge clk);
      if (bit_valid === 1'b1) begin
        if (first_k < 0) first_k = k;
        r = dut.lfsr_q;
        checks++;
        if (bit_out !== (int'(r) < exp_q[0])) begin
          errors++; $display("FAIL bit_vs_r k=%0d r=%0d got %b want %b", k, r, bit_out, int'(r) < exp_q[0]);
        end
        if (nbits < N) begin serial[nbits] = bit_out; seen[r] = 1'b1; end
        nbits++;
        ones += (bit_out === 1'b1) ? 1 : 0;
      end
      if (word_valid === 1'b1) begin done_k = k; break; end
    end
    in_valid = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (first_k != 1 || nbits != N || done_k != N + 1) begin
      errors++; $display("FAIL latency v=%0d got first=%0d bits=%0d done=%0d want 1/%0d/%0d", val, first_k, nbits, done_k, N, N + 1);
    end
    checks++;
    if ($countones(word_out) != exp_v || ones != exp_v) begin
      errors++; $display("FAIL popcount v=%0d got word=%0d serial=%0d want %0d", val, $countones(word_out), ones, exp_v);
    end
    checks++;
    if (word_out !== serial) begin
      errors++; $display("FAIL word_order v=%0d got %h want %h", val, word_out, serial);
    end
    checks++;
    if (seen !== {N{1'b1}}) begin
      errors++; $display("FAIL permutation v=%0d got seen=%b want all ones", val, seen);
    end
    if (exp_v == 0 || exp_v == N) begin
      exp_word = (exp_v == 0) ? '0 : '1;
      checks++;
      if (word_out !== exp_word) begin
        errors++; $display("FAIL word_extreme v=%0d got %h want %h", val, word_out, exp_word);
      end
    end
    if (hold_ready) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || word_valid !== 1'b0 || bit_out !== 1'b0) begin
        errors++; $display("FAIL return_idle v=%0d got rdy=%b wv=%b bit=%b want 1 0 0", val, in_ready, word_valid, bit_out);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_value = '0; word_ready = 1'b0;
    #12;
    checks++;
    if (bit_out !== 1'b0 || bit_valid !== 1'b0 || word_valid !== 1'b0 || word_out !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_values got bit=%b bv=%b wv=%b word=%h rdy=%b want 0 0 0 00 1", bit_out, bit_valid, word_valid, word_out, in_ready);
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || word_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset got rdy=%b wv=%b want 1 0", in_ready, word_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    int bits;
    bits = 0;
    in_value = (K+1)'(5); in_valid = 1'b1; word_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int i = 0; i < N && bits < 3; i++) begin
      @(negedge clk);
      if (bit_valid === 1'b1) bits++;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bit_out !== 1'b0 || bit_valid !== 1'b0 || word_valid !== 1'b0 || word_out !== '0) begin
      errors++; $display("FAIL async_reset got bit=%b bv=%b wv=%b word=%h want all 0", bit_out, bit_valid, word_valid, word_out);
    end
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      checks++;
      if (bit_valid !== 1'b0 || word_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL residual i=%0d got bv=%b wv=%b rdy=%b want 0 0 1", i, bit_valid, word_valid, in_ready);
      end
    end
  endtask

  task automatic test_basic();
    stream(5, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int a0;
    stream(0, 1'b1, 1'b0);
    a0 = last_accept;
    stream(8, 1'b1, 1'b0);
    checks++;
    if (last_accept - a0 != N + 2) begin
      errors++; $display("FAIL accept_spacing got %0d want %0d", last_accept - a0, N + 2);
    end
  endtask

  task automatic test_saturation();
    stream(12, 1'b1, 1'b0);
  endtask

  task automatic test_stall();
    logic [N-1:0] held;
    stream(3, 1'b0, 1'b1);
    held = word_out;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_value = (K+1)'(i % (N + 1));
      @(negedge clk);
      checks++;
      if (word_valid !== 1'b1 || word_out !== held || in_ready !== 1'b0 || bit_valid !== 1'b0) begin
        errors++; $display("FAIL stall i=%0d got wv=%b word=%h rdy=%b bv=%b want 1 %h 0 0", i, word_valid, word_out, in_ready, bit_valid, held);
      end
    end
    in_valid = 1'b0; word_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || word_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release got rdy=%b wv=%b want 1 0", in_ready, word_valid);
    end
  endtask

  task automatic test_sweep();
    for (int v = 0; v <= N; v++) stream(v, 1'b1, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_stall();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_stream_gen.md
Name: sc_stream_gen

Overview:
- Binary-to-stochastic converter (stochastic number generator, SNG). It is the source end of the bitstream path whose sink is the popcount accumulator.
- Accepts a binary value v (0..N) and emits an N-bit unipolar stochastic stream containing exactly v ones.
- The stream is emitted serially, one bit per cycle. It is also assembled into an N-bit parallel word so it can be handed directly to the accumulator's data_in.
- Bit positions are randomised by a full-period (de Bruijn) LFSR comparator.

Parameters:
- K, 3, log2 of stream length; legal range 2..8.
- N, 2**K, stream length in bits; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- in_value  input  K+1  binary value to encode; values > N saturate to N.
- in_valid  input  1  in_value is valid.
- in_ready  output  1  block idle and able to accept a value.
- bit_out  output  1  serial stochastic bit.
- bit_valid  output  1  bit_out is valid this cycle.
- word_out  output  N  assembled stream; bit i = i-th serial bit emitted.
- word_valid  output  1  word_out is complete and held.
- word_ready  input  1  consumer accepts word_out.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, count=0, value reg=0, LFSR=1, word_out=0, bit_out=0, bit_valid=0, word_valid=0. in_ready=1 once in IDLE.
- Reset mid-operation aborts the stream immediately: no partial word_valid, and all outputs take their reset values.
- LFSR is K bits, uses a maximal-length polynomial and de Bruijn zero insertion, and advances every cycle while state=RUN (held otherwise).
  - Required property: any N consecutive RUN-cycle outputs r form a permutation of 0..N-1.
  - The LFSR state persists across streams (not reseeded per stream).
- State machine: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, bit_valid=0, word_valid=0.
  - On in_valid at a posedge: latch v = min(in_value, N), clear word_out and count, go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle: bit_valid=1, bit_out = (r < v), where r = current LFSR state zero-extended to K+1 bits (unsigned).
  - At the posedge the block writes word_out[count]=bit_out, increments count and advances the LFSR.
  - After the N-th bit (count==N-1 at the edge): go to DONE.
- DONE:
  - word_valid=1; word_out is held stable; bit_valid=0; in_ready=0.
  - When word_ready=1 at a posedge: go to IDLE and drop word_valid.
  - word_ready while not in DONE has no effect.
- Latency: handshake accepted at edge t gives bit_valid high for cycles t+1..t+N; word_valid rises in cycle t+N+1.
  - Minimum period between accepted inputs: N+2 cycles (word_ready held high).
- Exactness: popcount(word_out) == v and the count of bit_out=1 over the stream == v, for every v in 0..N.
  - v=0 gives all zeros; v=N gives all ones.
- Width rules:
  - count is K bits and wraps to 0 after N-1; the wrap coincides with the exit to DONE.
  - The comparison is unsigned at K+1 bits.
- bit_out is 0 whenever bit_valid=0.

Test Plan (K=3, N=8):
- Reset asserted mid-RUN after 3 bits -> all outputs 0 asynchronously (before the next edge); after release: in_ready=1, word_valid=0, no residual bits.
- in_value=5 with word_ready tied high -> bit_valid high exactly 8 cycles starting 1 cycle after accept; five 1s on bit_out; word_valid 1 cycle later with popcount(word_out)=5, bit i matching serial bit i.
- in_value=0 and in_value=8 back-to-back -> word_out=8'h00 then 8'hFF; second accept occurs exactly N+2 cycles after the first.
- in_value=12 (saturation) -> treated as 8; word_out=8'hFF.
- Stall: word_ready low for 10 cycles in DONE -> word_out and word_valid held unchanged, in_ready=0; in_valid pulses in RUN/DONE ignored; word_ready=1 -> IDLE next cycle.
- Permutation check: 4 consecutive streams -> per stream, the sampled LFSR r values cover {0..7} exactly once; sweep v=0..8 and check popcount == v for every v.
